// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder: turns decoded op requests into 32-bit
// instruction words and writes them to instruction memory at an auto-incrementing address.
module instr_encoder #(
    parameter int AW = 10,
    parameter logic [AW-1:0] BASE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_Enc_valid,
    output logic          o_Enc_ready,
    input  logic [5:0]    i_Enc_op,
    input  logic [4:0]    i_Enc_rs,
    input  logic [4:0]    i_Enc_rt,
    input  logic [4:0]    i_Enc_rd,
    input  logic [4:0]    i_Enc_shamt,
    input  logic [31:0]   i_Enc_imm,
    input  logic          i_Enc_addrLoad,
    input  logic [AW-1:0] i_Enc_addr,
    output logic          o_Enc_we,
    output logic [AW-1:0] o_Enc_addr,
    output logic [31:0]   o_Enc_data,
    output logic          o_Enc_err,
    output logic          o_Enc_full,
    output logic [15:0]   o_Enc_count
);

    localparam logic [5:0] OP_JR     = 6'd16;
    localparam logic [5:0] OP_ITYPE  = 6'd17;
    localparam logic [5:0] OP_LUI    = 6'd22;
    localparam logic [5:0] OP_BLEZ   = 6'd32;
    localparam logic [5:0] OP_BGTZ   = 6'd33;
    localparam logic [5:0] OP_J      = 6'd34;
    localparam logic [5:0] OP_JAL    = 6'd35;
    localparam logic [5:0] OP_LI     = 6'd36;
    localparam logic [5:0] OP_NOP    = 6'd37;
    localparam logic [AW-1:0] LAST   = '1;

    typedef enum logic [1:0] {IDLE, SECOND, FULL} state_t;

    state_t        state;
    logic [AW-1:0] next_addr;
    logic [4:0]    li_rt;
    logic [15:0]   li_lo;
    logic          accept;
    logic          at_last;

    // Single-word encoding; for li this yields the lui (upper-half) word.
    function automatic logic [31:0] encode(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [31:0] imm
    );
        logic [5:0]  funct;
        logic [5:0]  opc;
        logic [4:0]  f_rs;
        logic [4:0]  f_rt;
        logic [4:0]  f_rd;
        logic [4:0]  f_sh;
        logic [31:0] word;
        funct = 6'h00;
        opc   = 6'h00;
        f_rs  = rs;
        f_rt  = rt;
        f_rd  = rd;
        f_sh  = shamt;
        word  = 32'h0;
        if (op <= OP_JR) begin
            case (op)
                6'd0:    funct = 6'h20;
                6'd1:    funct = 6'h21;
                6'd2:    funct = 6'h22;
                6'd3:    funct = 6'h23;
                6'd4:    funct = 6'h24;
                6'd5:    funct = 6'h25;
                6'd6:    funct = 6'h26;
                6'd7:    funct = 6'h27;
                6'd8:    funct = 6'h2A;
                6'd9:    funct = 6'h2B;
                6'd10:   funct = 6'h00;
                6'd11:   funct = 6'h02;
                6'd12:   funct = 6'h03;
                6'd13:   funct = 6'h04;
                6'd14:   funct = 6'h06;
                6'd15:   funct = 6'h07;
                default: funct = 6'h08;
            endcase
            if (op inside {6'd10, 6'd11, 6'd12}) f_rs = 5'd0;
            if (op inside {6'd13, 6'd14, 6'd15}) f_sh = 5'd0;
            if (op == OP_JR) begin
                f_rt = 5'd0;
                f_rd = 5'd0;
                f_sh = 5'd0;
            end
            word = {6'h00, f_rs, f_rt, f_rd, f_sh, funct};
        end else if (op <= OP_BGTZ) begin
            case (op - OP_ITYPE)
                6'd0:    opc = 6'h08;
                6'd1:    opc = 6'h09;
                6'd2:    opc = 6'h0C;
                6'd3:    opc = 6'h0D;
                6'd4:    opc = 6'h0E;
                6'd5:    opc = 6'h0F;
                6'd6:    opc = 6'h23;
                6'd7:    opc = 6'h20;
                6'd8:    opc = 6'h2B;
                6'd9:    opc = 6'h28;
                6'd10:   opc = 6'h0A;
                6'd11:   opc = 6'h0B;
                6'd12:   opc = 6'h01;
                6'd13:   opc = 6'h04;
                6'd14:   opc = 6'h05;
                6'd15:   opc = 6'h06;
                default: opc = 6'h07;
            endcase
            if (op == OP_LUI) f_rs = 5'd0;
            if (op == OP_BLEZ || op == OP_BGTZ) f_rt = 5'd0;
            word = {opc, f_rs, f_rt, imm[15:0]};
        end else if (op == OP_J) begin
            word = {6'h02, imm[25:0]};
        end else if (op == OP_JAL) begin
            word = {6'h03, imm[25:0]};
        end else if (op == OP_LI) begin
            word = {6'h0F, 5'd0, rt, imm[31:16]};
        end
        return word;
    endfunction

    // An address load blocks acceptance so it always wins over a request.
    assign o_Enc_ready = (state == IDLE) && !i_Enc_addrLoad;
    assign accept      = i_Enc_valid && o_Enc_ready;
    assign at_last     = (next_addr == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            next_addr   <= BASE;
            li_rt       <= 5'd0;
            li_lo       <= 16'd0;
            o_Enc_we    <= 1'b0;
            o_Enc_addr  <= '0;
            o_Enc_data  <= 32'h0;
            o_Enc_err   <= 1'b0;
            o_Enc_full  <= 1'b0;
            o_Enc_count <= 16'd0;
        end else begin
            o_Enc_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Enc_addrLoad) begin
                        next_addr  <= i_Enc_addr;
                        o_Enc_full <= 1'b0;
                    end else if (accept) begin
                        if (i_Enc_op > OP_NOP) begin
                            o_Enc_err <= 1'b1;
                        end else begin
                            o_Enc_we    <= 1'b1;
                            o_Enc_addr  <= next_addr;
                            o_Enc_data  <= encode(i_Enc_op, i_Enc_rs, i_Enc_rt, i_Enc_rd,
                                                  i_Enc_shamt, i_Enc_imm);
                            o_Enc_count <= o_Enc_count + 16'd1;
                            next_addr   <= next_addr + 1'b1;
                            // A li landing on the last address loses its ori half.
                            if (at_last) begin
                                state      <= FULL;
                                o_Enc_full <= 1'b1;
                                if (i_Enc_op == OP_LI) o_Enc_err <= 1'b1;
                            end else if (i_Enc_op == OP_LI) begin
                                state <= SECOND;
                                li_rt <= i_Enc_rt;
                                li_lo <= i_Enc_imm[15:0];
                            end
                        end
                    end
                end
                SECOND: begin
                    o_Enc_we    <= 1'b1;
                    o_Enc_addr  <= next_addr;
                    o_Enc_data  <= {6'h0D, li_rt, li_rt, li_lo};
                    o_Enc_count <= o_Enc_count + 16'd1;
                    next_addr   <= next_addr + 1'b1;
                    if (at_last) begin
                        state      <= FULL;
                        o_Enc_full <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                FULL: begin
                    if (i_Enc_addrLoad) begin
                        next_addr  <= i_Enc_addr;
                        o_Enc_full <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized
// run scored against a table-driven reference model.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid_a, valid_b, load_a, load_b;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] imm;
    logic [9:0]  load_addr;

    logic        a_ready, a_we, a_err, a_full;
    logic [9:0]  a_addr;
    logic [31:0] a_data;
    logic [15:0] a_count;
    logic        b_ready, b_we, b_err, b_full;
    logic [2:0]  b_addr;
    logic [31:0] b_data;
    logic [15:0] b_count;

    int n_cmp  = 0;
    int n_fail = 0;

    int funct_tab [17] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8};
    int opc_tab   [17] = '{8, 9, 12, 13, 14, 15, 35, 32, 43, 40, 10, 11, 1, 4, 5, 6, 7};

    instr_encoder #(.AW(10), .BASE(10'd0)) dut_a (
        .clk(clk), .rst(rst), .i_Enc_valid(valid_a), .o_Enc_ready(a_ready),
        .i_Enc_op(op), .i_Enc_rs(rs), .i_Enc_rt(rt), .i_Enc_rd(rd), .i_Enc_shamt(sh),
        .i_Enc_imm(imm), .i_Enc_addrLoad(load_a), .i_Enc_addr(load_addr),
        .o_Enc_we(a_we), .o_Enc_addr(a_addr), .o_Enc_data(a_data),
        .o_Enc_err(a_err), .o_Enc_full(a_full), .o_Enc_count(a_count)
    );

    instr_encoder #(.AW(3), .BASE(3'd6)) dut_b (
        .clk(clk), .rst(rst), .i_Enc_valid(valid_b), .o_Enc_ready(b_ready),
        .i_Enc_op(op), .i_Enc_rs(rs), .i_Enc_rt(rt), .i_Enc_rd(rd), .i_Enc_shamt(sh),
        .i_Enc_imm(imm), .i_Enc_addrLoad(load_b), .i_Enc_addr(load_addr[2:0]),
        .o_Enc_we(b_we), .o_Enc_addr(b_addr), .o_Enc_data(b_data),
        .o_Enc_err(b_err), .o_Enc_full(b_full), .o_Enc_count(b_count)
    );

    // Reference encoding built from field positions; hi selects lui vs ori half of li.
    function automatic logic [31:0] ref_word(input int o, input int s, input int t,
                                             input int d, input int h,
                                             input logic [31:0] im, input bit hi);
        logic [31:0] w;
        w = 32'h0;
        if (o <= 16) begin
            if (o >= 10 && o <= 12) s = 0;
            if (o >= 13 && o <= 15) h = 0;
            if (o == 16) begin t = 0; d = 0; h = 0; end
            w = (s << 21) | (t << 16) | (d << 11) | (h << 6) | funct_tab[o];
        end else if (o <= 33) begin
            if (o == 22) s = 0;
            if (o == 32 || o == 33) t = 0;
            w = (opc_tab[o-17] << 26) | (s << 21) | (t << 16) | (im & 32'hFFFF);
        end else if (o == 34) begin
            w = (2 << 26) | (im & 32'h03FF_FFFF);
        end else if (o == 35) begin
            w = (3 << 26) | (im & 32'h03FF_FFFF);
        end else if (o == 36) begin
            w = hi ? ((15 << 26) | (t << 16) | (im >> 16))
                   : ((13 << 26) | (t << 21) | (t << 16) | (im & 32'hFFFF));
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; load_a = 1'b0; load_b = 1'b0;
        op = 6'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; sh = 5'd0; imm = 32'h0; load_addr = 10'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (a_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %b want 0", a_we); end
        n_cmp++; if (a_addr !== 10'd0) begin n_fail++; $display("[TB] FAIL reset_addr: got %0d want 0", a_addr); end
        n_cmp++; if (a_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h want 0", a_data); end
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 1", a_ready); end
        n_cmp++; if ({a_err, a_full} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_err_full: got %b want 00", {a_err, a_full}); end
        n_cmp++; if (a_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d want 0", a_count); end
        n_cmp++; if ({b_ready, b_full, b_err} !== 3'b100) begin n_fail++; $display("[TB] FAIL reset_b: got %b want 100", {b_ready, b_full, b_err}); end
    endtask

    task automatic test_sequence();
        valid_a = 1'b1; op = 6'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; sh = 5'd0; imm = 32'h0;
        tick();
        n_cmp++; if ({a_we, a_addr, a_data} !== {1'b1, 10'd0, 32'h00221820}) begin n_fail++; $display("[TB] FAIL seq_add: got we=%b addr=%0d data=%h want 1/0/00221820", a_we, a_addr, a_data); end
        op = 6'd17; rs = 5'd0; rt = 5'd5; imm = 32'h0000FFFF;
        tick();
        n_cmp++; if ({a_we, a_addr, a_data} !== {1'b1, 10'd1, 32'h2005FFFF}) begin n_fail++; $display("[TB] FAIL seq_addi: got we=%b addr=%0d data=%h want 1/1/2005ffff", a_we, a_addr, a_data); end
        op = 6'd10; rs = 5'd7; rt = 5'd3; rd = 5'd2; sh = 5'd4;
        tick();
        n_cmp++; if ({a_we, a_addr, a_data} !== {1'b1, 10'd2, 32'h00031100}) begin n_fail++; $display("[TB] FAIL seq_sll: got we=%b addr=%0d data=%h want 1/2/00031100", a_we, a_addr, a_data); end
        valid_a = 1'b0;
        tick();
        n_cmp++; if ({a_we, a_count} !== {1'b0, 16'd3}) begin n_fail++; $display("[TB] FAIL seq_idle: got we=%b count=%0d want 0/3", a_we, a_count); end
    endtask

    task automatic test_back_to_back();
        valid_a = 1'b1; op = 6'd36; rt = 5'd8; imm = 32'h12345678;
        tick();
        n_cmp++; if ({a_we, a_addr, a_data} !== {1'b1, 10'd3, 32'h3C081234}) begin n_fail++; $display("[TB] FAIL li_lui: got we=%b addr=%0d data=%h want 1/3/3c081234", a_we, a_addr, a_data); end
        n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL li_ready_low: got %b want 0", a_ready); end
        op = 6'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; sh = 5'd0; imm = 32'h0;
        tick();
        n_cmp++; if ({a_we, a_addr, a_data} !== {1'b1, 10'd4, 32'h35085678}) begin n_fail++; $display("[TB] FAIL li_ori: got we=%b addr=%0d data=%h want 1/4/35085678", a_we, a_addr, a_data); end
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL li_ready_back: got %b want 1", a_ready); end
        tick();
        n_cmp++; if ({a_we, a_addr, a_data} !== {1'b1, 10'd5, 32'h00221820}) begin n_fail++; $display("[TB] FAIL li_queued: got we=%b addr=%0d data=%h want 1/5/00221820", a_we, a_addr, a_data); end
        valid_a = 1'b0;
    endtask

    task automatic test_branch_jump();
        valid_a = 1'b1; op = 6'd29; rs = 5'd4; rt = 5'b10000; imm = 32'd3;
        tick();
        n_cmp++; if ({a_we, a_addr, a_data} !== {1'b1, 10'd6, 32'h04900003}) begin n_fail++; $display("[TB] FAIL regimm: got we=%b addr=%0d data=%h want 1/6/04900003", a_we, a_addr, a_data); end
        op = 6'd34; imm = 32'h100;
        tick();
        n_cmp++; if ({a_we, a_addr, a_data} !== {1'b1, 10'd7, 32'h08000100}) begin n_fail++; $display("[TB] FAIL jump: got we=%b addr=%0d data=%h want 1/7/08000100", a_we, a_addr, a_data); end
        valid_a = 1'b0;
    endtask

    task automatic test_bad_op();
        valid_a = 1'b1; op = 6'd40;
        tick();
        n_cmp++; if ({a_we, a_err} !== 2'b01) begin n_fail++; $display("[TB] FAIL bad_op: got we=%b err=%b want 0/1", a_we, a_err); end
        op = 6'd37;
        repeat (10) tick();
        valid_a = 1'b0;
        tick();
        n_cmp++; if ({a_err, a_count} !== {1'b1, 16'd18}) begin n_fail++; $display("[TB] FAIL err_sticky: got err=%b count=%0d want 1/18", a_err, a_count); end
    endtask

    task automatic test_random();
        logic [31:0] q_data [$];
        int          q_addr [$];
        int          m_addr, m_count;
        bit          m_err, exp_ready;
        logic [31:0] e_data;
        int          e_addr;
        do_reset();
        m_addr = 0; m_count = 0; m_err = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            valid_a = ($urandom_range(0, 3) != 0);
            op  = 6'($urandom_range(0, 39));
            rs  = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
            imm = $urandom();
            #1;
            exp_ready = (q_data.size() == 0);
            n_cmp++; if (a_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL rnd_ready cyc %0d: got %b want %b", cyc, a_ready, exp_ready); end
            if (valid_a && exp_ready) begin
                if (op > 37) begin
                    m_err = 1'b1;
                end else begin
                    q_data.push_back(ref_word(int'(op), int'(rs), int'(rt), int'(rd), int'(sh), imm, 1'b1));
                    q_addr.push_back(m_addr);
                    m_addr = (m_addr + 1) % 1024;
                    if (op == 6'd36) begin
                        q_data.push_back(ref_word(int'(op), int'(rs), int'(rt), int'(rd), int'(sh), imm, 1'b0));
                        q_addr.push_back(m_addr);
                        m_addr = (m_addr + 1) % 1024;
                    end
                end
            end
            tick();
            if (q_data.size() > 0) begin
                e_data = q_data.pop_front();
                e_addr = q_addr.pop_front();
                m_count++;
                n_cmp++; if ({a_we, a_addr, a_data} !== {1'b1, 10'(e_addr), e_data}) begin n_fail++; $display("[TB] FAIL rnd_write cyc %0d: got we=%b addr=%0d data=%h want 1/%0d/%h", cyc, a_we, a_addr, a_data, e_addr, e_data); end
            end else begin
                n_cmp++; if (a_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_nowrite cyc %0d: got we=%b want 0", cyc, a_we); end
            end
            n_cmp++; if (a_err !== m_err) begin n_fail++; $display("[TB] FAIL rnd_err cyc %0d: got %b want %b", cyc, a_err, m_err); end
        end
        valid_a = 1'b0;
        tick();
        n_cmp++; if (a_count !== 16'(m_count)) begin n_fail++; $display("[TB] FAIL rnd_count: got %0d want %0d", a_count, m_count); end
    endtask

    task automatic test_full();
        do_reset();
        valid_b = 1'b1; op = 6'd37;
        tick();
        n_cmp++; if ({b_we, b_addr, b_full} !== {1'b1, 3'd6, 1'b0}) begin n_fail++; $display("[TB] FAIL full_w6: got we=%b addr=%0d full=%b want 1/6/0", b_we, b_addr, b_full); end
        tick();
        n_cmp++; if ({b_we, b_addr, b_full, b_ready} !== {1'b1, 3'd7, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL full_w7: got we=%b addr=%0d full=%b ready=%b want 1/7/1/0", b_we, b_addr, b_full, b_ready); end
        tick();
        tick();
        n_cmp++; if ({b_we, b_count} !== {1'b0, 16'd2}) begin n_fail++; $display("[TB] FAIL full_ignore: got we=%b count=%0d want 0/2", b_we, b_count); end
        load_b = 1'b1; load_addr = 10'd0;
        tick();
        n_cmp++; if ({b_we, b_full} !== 2'b00) begin n_fail++; $display("[TB] FAIL full_load: got we=%b full=%b want 0/0", b_we, b_full); end
        load_b = 1'b0;
        tick();
        n_cmp++; if ({b_we, b_addr} !== {1'b1, 3'd0}) begin n_fail++; $display("[TB] FAIL full_w0: got we=%b addr=%0d want 1/0", b_we, b_addr); end
        load_b = 1'b1; load_addr = 10'd7;
        #1;
        n_cmp++; if (b_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL load_wins: got ready=%b want 0", b_ready); end
        tick();
        n_cmp++; if (b_we !== 1'b0) begin n_fail++; $display("[TB] FAIL load_nowrite: got we=%b want 0", b_we); end
        load_b = 1'b0; op = 6'd36; rt = 5'd8; imm = 32'h12345678;
        tick();
        n_cmp++; if ({b_we, b_addr, b_data} !== {1'b1, 3'd7, ref_word(36, 0, 8, 0, 0, 32'h12345678, 1'b1)}) begin n_fail++; $display("[TB] FAIL li_last_lui: got we=%b addr=%0d data=%h want 1/7/3c081234", b_we, b_addr, b_data); end
        n_cmp++; if ({b_full, b_err, b_ready} !== 3'b110) begin n_fail++; $display("[TB] FAIL li_last_flags: got full/err/ready=%b want 110", {b_full, b_err, b_ready}); end
        valid_b = 1'b0;
        tick();
        n_cmp++; if ({b_we, b_count} !== {1'b0, 16'd4}) begin n_fail++; $display("[TB] FAIL li_last_drop: got we=%b count=%0d want 0/4", b_we, b_count); end
    endtask

    task automatic test_reset_mid_li();
        do_reset();
        valid_a = 1'b1; op = 6'd36; rt = 5'd8; imm = 32'h12345678;
        tick();
        n_cmp++; if ({a_we, a_data} !== {1'b1, 32'h3C081234}) begin n_fail++; $display("[TB] FAIL rst_li_lui: got we=%b data=%h want 1/3c081234", a_we, a_data); end
        rst = 1'b1; valid_a = 1'b0;
        tick();
        n_cmp++; if ({a_we, a_addr, a_data, a_ready, a_err, a_full, a_count} !== {1'b0, 10'd0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0}) begin n_fail++; $display("[TB] FAIL rst_li_state: got we=%b addr=%0d data=%h ready=%b err=%b full=%b count=%0d want 0/0/0/1/0/0/0", a_we, a_addr, a_data, a_ready, a_err, a_full, a_count); end
        rst = 1'b0;
        tick();
        n_cmp++; if (a_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_li_no_ori: got we=%b want 0", a_we); end
        valid_a = 1'b1; op = 6'd37;
        tick();
        n_cmp++; if ({a_we, a_addr} !== {1'b1, 10'd0}) begin n_fail++; $display("[TB] FAIL rst_li_base: got we=%b addr=%0d want 1/0", a_we, a_addr); end
        valid_a = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_back_to_back();
        test_branch_jump();
        test_bad_op();
        test_random();
        test_full();
        test_reset_mid_li();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
